// File: rtl/stream_fifo_pkg.sv
// Shared constants and pointer helpers for the stream FIFO source slice.
package stream_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 2;
  localparam int unsigned STAT_WIDTH         = 16;
  localparam int unsigned PTR_MAX_WIDTH      = 9;

  // Occupancy from wrap-bit pointers, taken modulo 2**(aw+1).
  function automatic logic [PTR_MAX_WIDTH-1:0] ptr_level(
    input logic [PTR_MAX_WIDTH-1:0] wr,
    input logic [PTR_MAX_WIDTH-1:0] rd,
    input int unsigned              aw
  );
    logic [PTR_MAX_WIDTH:0]   span;
    logic [PTR_MAX_WIDTH-1:0] mask;
    span = (PTR_MAX_WIDTH+1)'(1) << (aw + 1);
    mask = PTR_MAX_WIDTH'(span - (PTR_MAX_WIDTH+1)'(1));
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// FIFO storage: register array, synchronous write port, asynchronous read port, no reset.
module stream_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo_source.sv
// Show-ahead ready/valid FIFO feeding the 8-bit stream consumer.
// Optional stats counters enabled by defining STREAM_FIFO_SOURCE_STATS_EN.
module stream_fifo_source
  import stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
`ifdef STREAM_FIFO_SOURCE_STATS_EN
 ,output logic [STAT_WIDTH-1:0] accept_count,
  output logic [STAT_WIDTH-1:0] stall_count
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  // Flags derive only from registered pointers, so dn_ready never reaches up_ready.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign up_ready = !full;
  assign dn_valid = !empty;
  assign level    = PTR_W'(ptr_level(PTR_MAX_WIDTH'(wr_ptr_q),
                                     PTR_MAX_WIDTH'(rd_ptr_q), ADDR_WIDTH));

  assign wr_en = up_valid && up_ready;
  assign rd_en = dn_valid && dn_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (up_data),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (dn_data)
  );

`ifdef STREAM_FIFO_SOURCE_STATS_EN
  logic [STAT_WIDTH-1:0] accept_q, accept_d;
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    accept_d = accept_q;
    stall_d  = stall_q;
    if (wr_en && (accept_q != '1))                   accept_d = accept_q + STAT_WIDTH'(1);
    if (dn_valid && !dn_ready && (stall_q != '1))    stall_d  = stall_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_q <= '0;
      stall_q  <= '0;
    end else begin
      accept_q <= accept_d;
      stall_q  <= stall_d;
    end
  end

  assign accept_count = accept_q;
  assign stall_count  = stall_q;
`else
  // Stats disabled: no counters or extra ports.
`endif

endmodule
